// File: rtl/lms_fir3.sv
// lms_fir3: 3-tap adaptive FIR whose weights follow the LMS rule every clock.
// Products are full 2N-bit signed; every sum and weight update wraps modulo 2^N.
module lms_fir3 #(
  parameter int N        = 32,
  parameter int MU_SHIFT = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] X,
  input  logic [N-1:0] h0,
  input  logic [N-1:0] h1,
  input  logic [N-1:0] h2,
  input  logic [N-1:0] d,
  output logic [N-1:0] Y
);

  localparam int TAPS = 3;

  typedef logic signed [2*N-1:0] wide_t;

  function automatic wide_t sext(input logic [N-1:0] v);
    return $signed({{N{v[N-1]}}, v});
  endfunction

  logic [N-1:0] x_r [TAPS];
  logic [N-1:0] w_r [TAPS];

  wide_t        prod_s [TAPS];
  wide_t        upd_s  [TAPS];
  wide_t        acc_s;
  logic [N-1:0] yc_s;
  logic [N-1:0] e_s;
  logic         unused_s;

  // Filter output and error from the current taps, then each weight's LMS correction
  always_comb begin
    acc_s = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod_s[k] = sext(w_r[k]) * sext(x_r[k]);
      acc_s     = acc_s + prod_s[k];
    end
    yc_s = acc_s[N-1:0];
    e_s  = d - yc_s;
    for (int k = 0; k < TAPS; k++) begin
      upd_s[k] = (sext(e_s) * sext(x_r[k])) >>> MU_SHIFT;
    end
  end

  // Only the low N bits of the wide sums are architecturally meaningful
  assign unused_s = ^{acc_s[2*N-1:N], upd_s[0][2*N-1:N], upd_s[1][2*N-1:N], upd_s[2][2*N-1:N]};

  // Delay line, weights and output register; reset keeps reloading the initial taps
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      x_r[0] <= '0;
      x_r[1] <= '0;
      x_r[2] <= '0;
      w_r[0] <= h0;
      w_r[1] <= h1;
      w_r[2] <= h2;
      Y      <= '0;
    end else begin
      x_r[0] <= X;
      x_r[1] <= x_r[0];
      x_r[2] <= x_r[1];
      for (int k = 0; k < TAPS; k++) begin
        w_r[k] <= w_r[k] + upd_s[k][N-1:0];
      end
      Y <= yc_s;
    end
  end

endmodule

// File: tb/tb_lms_fir3.sv
// Self-checking bench for lms_fir3: integer reference model plus hand-computed anchors.
module tb_lms_fir3;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] X   = 32'd0;
  logic [31:0] h0  = 32'd0;
  logic [31:0] h1  = 32'd0;
  logic [31:0] h2  = 32'd0;
  logic [31:0] d   = 32'd0;
  logic [31:0] Y;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // reference state: taps newest-first, weights, output
  int mx [3];
  int mw [3];
  int my;

  int exp2 [6] = '{0, 5, 440, 955, 1120, 1090};

  lms_fir3 #(.N(32), .MU_SHIFT(6)) dut (
    .clk(clk), .clr(clr), .X(X), .h0(h0), .h1(h1), .h2(h2), .d(d), .Y(Y)
  );

  always #5 clk = ~clk;

  function automatic int fir_y(int w0, int w1, int w2, int x0, int x1, int x2);
    longint acc;
    acc = longint'(w0) * longint'(x0) + longint'(w1) * longint'(x1) + longint'(w2) * longint'(x2);
    return acc[31:0];
  endfunction

  function automatic int lms_w(int w, int e, int x);
    longint p;
    p = (longint'(e) * longint'(x)) >>> 6;
    return w + p[31:0];
  endfunction

  // reference model: reset loads h, otherwise one LMS step per edge
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      mx <= '{0, 0, 0};
      mw <= '{int'(h0), int'(h1), int'(h2)};
      my <= 0;
    end else begin
      my <= fir_y(mw[0], mw[1], mw[2], mx[0], mx[1], mx[2]);
      for (int k = 0; k < 3; k++)
        mw[k] <= lms_w(mw[k], int'(d) - fir_y(mw[0], mw[1], mw[2], mx[0], mx[1], mx[2]), mx[k]);
      mx <= '{int'(X), mx[0], mx[1]};
    end
  end

  // compare DUT output with the model every cycle, away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (Y !== my[31:0]) begin
        bad++;
        $display("FAIL model_y t=%0t got=%0d want=%0d", $time, $signed(Y), my);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rst_to(input int a, input int b, input int c);
    h0  = a;
    h1  = b;
    h2  = c;
    X   = 32'd0;
    d   = 32'd0;
    clr = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // reset and idle with zero input
    rst_to(1, 2, 1);
    chk_en = 1'b1;
    chk("rst_y", $signed(Y), 0);
    d   = 32'd1100;
    clr = 1'b1;
    repeat (10) tick();
    chk("idle_y", $signed(Y), 0);
    chk("idle_w0", mw[0], 1);
    chk("idle_w1", mw[1], 2);
    chk("idle_w2", mw[2], 1);

    // convergence toward d=1100
    rst_to(1, 2, 1);
    X   = 32'd5;
    d   = 32'd1100;
    clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("conv_y", $signed(Y), exp2[i]);
      if (i == 4) begin
        chk("conv_w0", mw[0], 146);
        chk("conv_w1", mw[1], 62);
        chk("conv_w2", mw[2], 10);
      end
    end
    repeat (5) tick();
    chk("steady_y", $signed(Y), 1090);
    chk("steady_w0", mw[0], 146);

    // asynchronous reset mid-run, then the sequence must replay
    rst_to(1, 2, 1);
    X   = 32'd5;
    d   = 32'd1100;
    clr = 1'b1;
    repeat (3) tick();
    clr = 1'b0;
    #1;
    chk("midrst_y", $signed(Y), 0);
    chk("midrst_w0", mw[0], 1);
    tick();
    clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("replay_y", $signed(Y), exp2[i]);
    end

    // small target d=70
    rst_to(1, 2, 1);
    X   = 32'd5;
    d   = 32'd70;
    clr = 1'b1;
    tick();
    chk("small_y1", $signed(Y), 0);
    tick();
    chk("small_y2", $signed(Y), 5);
    chk("small_w0a", mw[0], 6);
    tick();
    chk("small_y3", $signed(Y), 40);
    chk("small_w0b", mw[0], 8);
    chk("small_w1b", mw[1], 4);

    // negative error, shift rounds toward -inf
    rst_to(1, 2, 1);
    X   = 32'd5;
    d   = 32'd0;
    clr = 1'b1;
    tick();
    tick();
    chk("neg_y2", $signed(Y), 5);
    chk("neg_w0", mw[0], 0);
    tick();
    chk("neg_y3", $signed(Y), 10);
    repeat (20) tick();

    // wrap on a large product
    rst_to(2, 0, 0);
    X   = 32'h7FFF_FFFF;
    d   = 32'd0;
    clr = 1'b1;
    tick();
    chk("wrap_y1", $signed(Y), 0);
    tick();
    chk("wrap_y2", $signed(Y), -2);
    chk("wrap_w0", mw[0], 67108865);
    repeat (10) tick();

    // randomized traffic with sporadic resets; h wiggles even while clr=1
    clr = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i < 400) begin
        h0 = $urandom_range(0, 8) - 32'd4;
        h1 = $urandom_range(0, 8) - 32'd4;
        h2 = $urandom_range(0, 8) - 32'd4;
        X  = $urandom_range(0, 40) - 32'd20;
        d  = $urandom_range(0, 4000) - 32'd2000;
      end else begin
        h0 = $urandom;
        h1 = $urandom;
        h2 = $urandom;
        X  = $urandom;
        d  = $urandom;
      end
      if ($urandom_range(0, 29) == 0)
        clr = 1'b0;
      else
        clr = 1'b1;
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
